// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: two-requester front end for one single-port data memory.
// Port 0 = core load/store path, port 1 = DMA/debug; one access in flight.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   pX_req/we/addr      request (held until pX_gnt), 1=write, byte address
//   pX_wdata/mask       write data and byte enables
//   pX_gnt              one-cycle pulse in the cycle the command hits memory
//   pX_rvalid/rdata     one-cycle read-return strobe, read word held after
//   mem_cs/mem_wr       active-low chip select / write strobe (0 = write)
//   mem_addr/mask/wdata word-aligned address, byte enables, write data
//   mem_rdata           read data, valid RD_LAT cycles after the access
//   busy                high whenever the sequencer is not idle
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin conflict
// resolution; otherwise port 0 has fixed priority.
module dmem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_mask,
    output logic                p0_gnt,
    output logic                p0_rvalid,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_mask,
    output logic                p1_gnt,
    output logic                p1_rvalid,
    output logic [DATA_W-1:0]   p1_rdata,
    output logic                mem_cs,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_mask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

    logic [1:0]        state;
    logic [3:0]        lat_cnt;
    logic              owner;
    logic              any_req;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_mask;

    assign any_req = p0_req | p1_req;
    assign busy    = (state != S_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner;

    // On conflict the port that did not win last time goes first.
    assign pick = p1_req & (~p0_req | ~last_winner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= 1'b1;
        end else if (state == S_IDLE && any_req) begin
            last_winner <= pick;
        end
    end
`else
    assign pick = p1_req & ~p0_req;
`endif

    always_comb begin
        sel_we    = pick ? p1_we    : p0_we;
        sel_addr  = pick ? p1_addr  : p0_addr;
        sel_wdata = pick ? p1_wdata : p0_wdata;
        sel_mask  = pick ? p1_mask  : p0_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lat_cnt   <= '0;
            owner     <= 1'b0;
            mem_cs    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= '0;
            mem_mask  <= '0;
            mem_wdata <= '0;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state     <= S_ACCESS;
                        owner     <= pick;
                        // An all-zero write mask is granted but never
                        // touches the memory.
                        mem_cs    <= sel_we && (sel_mask == '0);
                        mem_wr    <= ~sel_we;
                        mem_addr  <= sel_addr & ALIGN;
                        mem_mask  <= sel_we ? sel_mask : '1;
                        mem_wdata <= sel_wdata;
                        p0_gnt    <= ~pick;
                        p1_gnt    <= pick;
                    end
                end
                S_ACCESS: begin
                    mem_cs <= 1'b1;
                    mem_wr <= 1'b1;
                    // mem_wr still holds the strobe of this access.
                    if (mem_wr) begin
                        state   <= S_WAIT;
                        lat_cnt <= LAT_INIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Last WAIT cycle is the one carrying mem_rdata.
                    if (lat_cnt == '0) begin
                        state <= S_IDLE;
                        if (owner) begin
                            p1_rdata  <= mem_rdata;
                            p1_rvalid <= 1'b1;
                        end else begin
                            p0_rdata  <= mem_rdata;
                            p0_rvalid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench for dmem_port_arbiter.
// Instance dut uses RD_LAT=2, instance q_dut uses RD_LAT=1.
module tb_dmem_port_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_mask, p1_mask;

    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_cs, mem_wr, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;

    logic        q_p0_gnt, q_p0_rvalid, q_p1_gnt, q_p1_rvalid;
    logic [31:0] q_p0_rdata, q_p1_rdata;
    logic        q_mem_cs, q_mem_wr, q_busy;
    logic [31:0] q_mem_addr, q_mem_wdata, q_mem_rdata;
    logic [3:0]  q_mem_mask;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb[$];
    exp_t qsb[$];

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_mask(p0_mask),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_mask(p1_mask),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_mask(mem_mask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) q_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_mask(p0_mask),
        .p0_gnt(q_p0_gnt), .p0_rvalid(q_p0_rvalid), .p0_rdata(q_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_mask(p1_mask),
        .p1_gnt(q_p1_gnt), .p1_rvalid(q_p1_rvalid), .p1_rdata(q_p1_rdata),
        .mem_cs(q_mem_cs), .mem_wr(q_mem_wr), .mem_addr(q_mem_addr),
        .mem_mask(q_mem_mask), .mem_wdata(q_mem_wdata),
        .mem_rdata(q_mem_rdata), .busy(q_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents; data only appears on the bus in the exact
    // latency cycle, a poison word otherwise.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == 32'h20) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction

    logic        m_hit0, m_hit1, q_hit;
    logic [31:0] m_a0, m_a1, q_a;
    always @(posedge clk) begin
        m_hit0 <= !mem_cs && mem_wr;
        m_a0   <= mem_addr;
        m_hit1 <= m_hit0;
        m_a1   <= m_a0;
        q_hit  <= !q_mem_cs && q_mem_wr;
        q_a    <= q_mem_addr;
    end
    assign mem_rdata   = (m_hit1 === 1'b1) ? rd_word(m_a1) : 32'hBAD0BAD0;
    assign q_mem_rdata = (q_hit === 1'b1) ? rd_word(q_a) : 32'hBAD1BAD1;

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_mask = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_mask = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_cs !== 1'b1 || mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL reset_strobes: cs=%b wr=%b want 1 1", mem_cs, mem_wr);
        end
        checks++;
        if (mem_addr !== 0 || mem_mask !== 0 || mem_wdata !== 0) begin
            errors++;
            $display("FAIL reset_cmd: addr=%h mask=%b wdata=%h want 0",
                     mem_addr, mem_mask, mem_wdata);
        end
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 0000",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid});
        end
        checks++;
        if (p0_rdata !== 0 || p1_rdata !== 0) begin
            errors++;
            $display("FAIL reset_rdata: got %h %h want 0", p0_rdata, p1_rdata);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_write();
        p0_req = 1; p0_we = 1; p0_addr = 32'h104;
        p0_wdata = 32'hA5A5A5A5; p0_mask = 4'b0011;
        @(negedge clk);
        checks++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wr_gnt: p0=%b p1=%b want 1 0", p0_gnt, p1_gnt);
        end
        checks++;
        if (mem_cs !== 1'b0 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL wr_strobes: cs=%b wr=%b want 0 0", mem_cs, mem_wr);
        end
        checks++;
        if (mem_addr !== 32'h104 || mem_mask !== 4'b0011
            || mem_wdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wr_cmd: addr=%h mask=%b wdata=%h want 104 0011 a5a5a5a5",
                     mem_addr, mem_mask, mem_wdata);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_cs !== 1'b1 || p0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: busy=%b cs=%b gnt=%b want 0 1 0",
                     busy, mem_cs, p0_gnt);
        end
    endtask

    task automatic test_read();
        exp_t e;
        int   n;
        bit   found;
        bit   cs_bad;
        e.port = 1'b1; e.data = 32'hDEADBEEF;
        sb.push_back(e);
        p1_req = 1; p1_we = 0; p1_addr = 32'h20;
        @(negedge clk);
        checks++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || mem_cs !== 1'b0
            || mem_wr !== 1'b1 || mem_addr !== 32'h20 || mem_mask !== 4'b1111) begin
            errors++;
            $display("FAIL rd_issue: gnt=%b%b cs=%b wr=%b addr=%h mask=%b want 10 0 1 20 1111",
                     p1_gnt, p0_gnt, mem_cs, mem_wr, mem_addr, mem_mask);
        end
        idle_inputs();
        n = 0; found = 0; cs_bad = 0;
        while (!found && n < 12) begin
            @(negedge clk);
            n++;
            if (p0_rvalid || p1_rvalid) found = 1;
            else if (mem_cs !== 1'b1) cs_bad = 1;
        end
        checks++;
        if (cs_bad) begin
            errors++;
            $display("FAIL rd_wait_cs: cs low during wait, want 1");
        end
        checks++;
        if (!found || n != 3) begin
            errors++;
            $display("FAIL rd_latency: rvalid after %0d cycles (found=%0d) want 3", n, found);
        end
        if (found) begin
            e = sb.pop_front();
            checks++;
            if ({p1_rvalid, p0_rvalid} !== {e.port, ~e.port}) begin
                errors++;
                $display("FAIL rd_port: rvalid p1p0=%b%b want 10", p1_rvalid, p0_rvalid);
            end
            checks++;
            if (p1_rdata !== e.data || busy !== 1'b0) begin
                errors++;
                $display("FAIL rd_data: got %h busy=%b want %h busy=0",
                         p1_rdata, busy, e.data);
            end
        end
        sb.delete();
        @(negedge clk);
        checks++;
        if (p1_rvalid !== 1'b0 || p1_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_hold: rvalid=%b rdata=%h want 0 deadbeef", p1_rvalid, p1_rdata);
        end
    endtask

    task automatic test_arbitration();
        exp_t e;
        logic exp_port [4];
        int   gi, ri, n;
`ifdef ARB_ROUND_ROBIN_EN
        exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            e.port = exp_port[i];
            e.data = rd_word(exp_port[i] ? 32'h80 : 32'h40);
            sb.push_back(e);
        end
        p0_req = 1; p0_we = 0; p0_addr = 32'h40;
        p1_req = 1; p1_we = 0; p1_addr = 32'h80;
        gi = 0; ri = 0; n = 0;
        while (ri < 4 && n < 80) begin
            @(negedge clk);
            n++;
            if (p0_gnt || p1_gnt) begin
                checks++;
                if ((p0_gnt && p1_gnt) || gi >= 4 || p1_gnt !== exp_port[gi & 3]) begin
                    errors++;
                    $display("FAIL arb_grant%0d: gnt p1p0=%b%b want port %0d",
                             gi, p1_gnt, p0_gnt, exp_port[gi & 3]);
                end
                gi++;
                if (gi == 4) begin
                    p0_req = 0;
                    p1_req = 0;
                end
            end
            if (p0_rvalid || p1_rvalid) begin
                e = sb.pop_front();
                checks++;
                if ({p1_rvalid, p0_rvalid} !== {e.port, ~e.port}) begin
                    errors++;
                    $display("FAIL arb_rvalid%0d: p1p0=%b%b want port %0d",
                             ri, p1_rvalid, p0_rvalid, e.port);
                end
                checks++;
                if ((e.port ? p1_rdata : p0_rdata) !== e.data) begin
                    errors++;
                    $display("FAIL arb_rdata%0d: got %h want %h", ri,
                             e.port ? p1_rdata : p0_rdata, e.data);
                end
                ri++;
            end
        end
        checks++;
        if (ri != 4 || gi != 4) begin
            errors++;
            $display("FAIL arb_count: grants=%0d returns=%0d want 4 4", gi, ri);
        end
        idle_inputs();
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mask_zero();
        p0_req = 1; p0_we = 1; p0_addr = 32'h200;
        p0_wdata = 32'h12345678; p0_mask = 4'b0000;
        @(negedge clk);
        checks++;
        if (p0_gnt !== 1'b1 || mem_cs !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mask0_access: gnt=%b cs=%b busy=%b want 1 1 1",
                     p0_gnt, mem_cs, busy);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (mem_cs !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mask0_done: cs=%b busy=%b want 1 0", mem_cs, busy);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   n;
        bit   stray;
        bit   found;
        p0_req = 1; p0_we = 0; p0_addr = 32'h30;
        @(negedge clk);
        checks++;
        if (p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL abort_gnt: got %b want 1", p0_gnt);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if (mem_cs !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: cs=%b busy=%b want 1 0", mem_cs, busy);
        end
        @(negedge clk);
        rst_n = 1;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (p0_rvalid || p1_rvalid) stray = 1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL abort_rvalid: stray rvalid after reset, want none");
        end
        e.port = 1'b0; e.data = rd_word(32'h44);
        sb.push_back(e);
        p0_req = 1; p0_we = 0; p0_addr = 32'h44;
        @(negedge clk);
        checks++;
        if (p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL abort_next_gnt: got %b want 1", p0_gnt);
        end
        idle_inputs();
        n = 0; found = 0;
        while (!found && n < 10) begin
            @(negedge clk);
            n++;
            if (p0_rvalid || p1_rvalid) found = 1;
        end
        checks++;
        if (!found || n != 3 || p0_rvalid !== 1'b1 || p0_rdata !== sb[0].data) begin
            errors++;
            $display("FAIL abort_next_rd: n=%0d rvalid=%b rdata=%h want 3 1 %h",
                     n, p0_rvalid, p0_rdata, sb[0].data);
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   g [3];
        int   k, r, n;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            e.port = 1'b0;
            e.data = rd_word(32'h100 + 32'(4 * i));
            qsb.push_back(e);
        end
        p0_req = 1; p0_we = 0; p0_addr = 32'h100;
        k = 0; r = 0; n = 0;
        while (r < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (q_p0_gnt) begin
                if (k > 0 && k < 3) begin
                    checks++;
                    if (cyc - g[k-1] != 3) begin
                        errors++;
                        $display("FAIL b2b_spacing%0d: got %0d want 3", k, cyc - g[k-1]);
                    end
                end
                if (k < 3) g[k] = cyc;
                k++;
                p0_addr = 32'h100 + 32'(4 * k);
                if (k == 3) p0_req = 0;
            end
            if (q_p0_rvalid || q_p1_rvalid) begin
                e = qsb.pop_front();
                checks++;
                if (q_p1_rvalid !== 1'b0 || r >= k || cyc - g[r] != 2) begin
                    errors++;
                    $display("FAIL b2b_lat%0d: p1rv=%b delay=%0d want 0 2",
                             r, q_p1_rvalid, cyc - g[r]);
                end
                checks++;
                if (q_p0_rdata !== e.data) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h want %h", r, q_p0_rdata, e.data);
                end
                r++;
            end
        end
        checks++;
        if (r != 3 || k != 3) begin
            errors++;
            $display("FAIL b2b_count: grants=%0d returns=%0d want 3 3", k, r);
        end
        idle_inputs();
        qsb.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_mask_zero();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
